// File: rtl/life_seed_controller.sv
// Seed/clear/step controller between the switch-key input interface and the life frame buffer.
// Turns coordinate and reset toggles into frame-buffer writes and paces generation steps.
module life_seed_controller #(
   parameter int unsigned COLS     = 80,
   parameter int unsigned ROWS     = 48,
   parameter int unsigned TICK_DIV = 12_500_000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  xcoordinate,
   input  logic [7:0]  ycoordinate,
   input  logic        coordinatesready,
   input  logic        start,
   input  logic        reset,
   input  logic        step_ack,
   output logic [11:0] mem_addr,
   output logic        mem_wdata,
   output logic        mem_we,
   output logic        step_req,
   output logic        busy,
   output logic [15:0] gen_count
);

   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned COORD_W = 8;
   localparam int unsigned GEN_W   = 16;
   localparam int unsigned CELLS   = COLS * ROWS;
   localparam int unsigned TICK_W  = $clog2(TICK_DIV);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      ST_ARM,
      ST_IDLE,
      ST_WRITE,
      ST_CLEAR,
      ST_STEP
   } state_t;

   state_t               state_q, state_d;
   logic                 cr_prev_q, cr_prev_d;
   logic                 rs_prev_q, rs_prev_d;
   logic                 pend_wr_q, pend_wr_d;
   logic                 pend_clr_q, pend_clr_d;
   logic [COORD_W-1:0]   x_q, x_d;
   logic [COORD_W-1:0]   y_q, y_d;
   logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [ADDR_W-1:0]    addr_d;
   logic                 wdata_d;
   logic                 we_d;
   logic                 req_d;
   logic                 busy_d;
   logic [GEN_W-1:0]     gen_d;

   logic                 cr_evt_c;
   logic                 rs_evt_c;
   logic                 in_range_c;
   logic [ADDR_W-1:0]    cell_addr_c;

   // ARM suppresses events so arbitrary toggle levels at power-up are ignored
   assign cr_evt_c    = (state_q != ST_ARM) && (coordinatesready != cr_prev_q);
   assign rs_evt_c    = (state_q != ST_ARM) && (reset != rs_prev_q);
   assign in_range_c  = (32'(x_q) < COLS) && (32'(y_q) < ROWS);
   assign cell_addr_c = ADDR_W'(32'(y_q) * COLS + 32'(x_q));

   // State register and all registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_ARM;
         cr_prev_q  <= 1'b0;
         rs_prev_q  <= 1'b0;
         pend_wr_q  <= 1'b0;
         pend_clr_q <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         clr_addr_q <= '0;
         tick_q     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= 1'b0;
         mem_we     <= 1'b0;
         step_req   <= 1'b0;
         busy       <= 1'b0;
         gen_count  <= '0;
      end else begin
         state_q    <= state_d;
         cr_prev_q  <= cr_prev_d;
         rs_prev_q  <= rs_prev_d;
         pend_wr_q  <= pend_wr_d;
         pend_clr_q <= pend_clr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         clr_addr_q <= clr_addr_d;
         tick_q     <= tick_d;
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         mem_we     <= we_d;
         step_req   <= req_d;
         busy       <= busy_d;
         gen_count  <= gen_d;
      end
   end

   // Next-state, pending-event and output logic
   always_comb begin
      state_d    = state_q;
      cr_prev_d  = coordinatesready;
      rs_prev_d  = reset;
      pend_wr_d  = pend_wr_q;
      pend_clr_d = pend_clr_q;
      x_d        = x_q;
      y_d        = y_q;
      clr_addr_d = clr_addr_q;
      tick_d     = tick_q;
      addr_d     = mem_addr;
      wdata_d    = 1'b0;
      we_d       = 1'b0;
      req_d      = 1'b0;
      busy_d     = (state_q == ST_CLEAR) || (state_q == ST_STEP);
      gen_d      = gen_count;

      case (state_q)
         ST_ARM: begin
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (pend_clr_q) begin
               state_d    = ST_CLEAR;
               pend_clr_d = 1'b0;
               gen_d      = '0;
               tick_d     = '0;
               clr_addr_d = '0;
            end else if (pend_wr_q) begin
               state_d = ST_WRITE;
            end else if (start && (tick_q == TICK_LAST)) begin
               state_d = ST_STEP;
            end else if (start) begin
               tick_d = tick_q + TICK_W'(1);
            end else begin
               tick_d = '0;
            end
         end
         ST_WRITE: begin
            if (in_range_c) begin
               we_d    = 1'b1;
               wdata_d = 1'b1;
               addr_d  = cell_addr_c;
            end
            pend_wr_d = 1'b0;
            state_d   = ST_IDLE;
         end
         ST_CLEAR: begin
            we_d   = 1'b1;
            addr_d = clr_addr_q;
            if (clr_addr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
            end else begin
               clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
         end
         ST_STEP: begin
            // request stays up until acknowledged, even if start drops
            if (step_ack) begin
               state_d = ST_IDLE;
               gen_d   = gen_count + GEN_W'(1);
               tick_d  = '0;
            end else begin
               req_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_ARM;
         end
      endcase

      // newest coordinate wins; repeated clear requests collapse into one flag
      if (cr_evt_c) begin
         pend_wr_d = 1'b1;
         x_d       = xcoordinate;
         y_d       = ycoordinate;
      end
      if (rs_evt_c) begin
         pend_clr_d = 1'b1;
      end
   end

endmodule

// File: doc/life_seed_controller.md
# life_seed_controller

Sits directly downstream of the switch/key input interface and turns its outputs into grid-memory operations. It detects the coordinate-ready and reset toggles, writes seed cells into the 80×48 frame buffer, and clears the buffer with a full-address sweep. While `start` is high it paces the life engine by issuing one generation-step request per tick period. It is the only writer of the frame buffer outside the life engine itself.

## Interface
Parameters:
- `COLS`, 80, grid width in cells
- `ROWS`, 48, grid height in cells
- `TICK_DIV`, 12_500_000, clocks per generation step (4 Hz at 50 MHz); minimum 2

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `xcoordinate`  in  8  seed column from input interface
- `ycoordinate`  in  8  seed row from input interface
- `coordinatesready`  in  1  toggle; each change = one new coordinate pair
- `start`  in  1  level; 1 = run generations
- `reset`  in  1  toggle; each change = clear grid request
- `step_ack`  in  1  life engine completed requested step (1-cycle pulse)
- `mem_addr`  out  12  frame-buffer address, `y*COLS + x`
- `mem_wdata`  out  1  cell value written
- `mem_we`  out  1  frame-buffer write strobe
- `step_req`  out  1  request one generation step
- `busy`  out  1  high during clear sweep or outstanding step
- `gen_count`  out  16  generations completed since last clear

## Operation
- Toggle detection: registers `cr_prev`, `rs_prev` hold last sampled `coordinatesready`/`reset`. Event = current ≠ prev.
- States: ARM, IDLE, WRITE, CLEAR, STEP.
- ARM: entered on reset; for one cycle loads `cr_prev`/`rs_prev` from inputs without raising events, then → IDLE. Prevents spurious events from arbitrary toggle levels at power-up.
- Events are captured into sticky flags `pend_wr` (with latched x,y) and `pend_clr` in any state; a coordinate event while `pend_wr` is set overwrites latched x,y (latest wins). A second reset event while `pend_clr` is set is absorbed.
- IDLE priority: `pend_clr` → CLEAR; else `pend_wr` → WRITE; else tick terminal with `start`=1 → STEP.
- WRITE: one cycle. If x<COLS and y<ROWS: `mem_we`=1, `mem_wdata`=1, `mem_addr`=y*COLS+x. Out of range: no write. Clears `pend_wr`; → IDLE.
- CLEAR: clears `pend_clr` on entry, `gen_count`←0, tick counter←0. Writes `mem_wdata`=0 to addresses 0..COLS*ROWS−1 (0..3839), one per cycle, ascending; after address 3839 → IDLE. Reset event during sweep sets `pend_clr` again → a second full sweep follows. Coordinate events during sweep stay pending and are written after.
- Tick counter: counts 0..TICK_DIV−1 only while `start`=1 and in IDLE; held at 0 while `start`=0. Terminal = TICK_DIV−1.
- STEP: `step_req`=1 held until `step_ack`; on ack `step_req` drops, `gen_count` increments (wraps 0xFFFF→0), counter←0, → IDLE. `start` falling during STEP does not cancel the request. Pending events wait until STEP exits.
- `busy` = state ∈ {CLEAR, STEP}.
- Arithmetic: address computed as 12-bit `y*COLS + x`; x, y compared as unsigned 8-bit.

## Timing
- Reset values: `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `step_req`=0, `busy`=0, `gen_count`=0, state=ARM, pending flags 0.
- All outputs registered.
- Coordinate toggle first sampled at edge k → `mem_we` high for exactly the cycle after edge k+2 (IDLE, nothing pending, not mid-step).
- Reset toggle sampled at edge k → first clear write (addr 0) in cycle after edge k+2; sweep occupies exactly 3840 consecutive `mem_we` cycles; `busy` high for those cycles.
- With `start`=1 continuously and `step_ack` returning 1 cycle after `step_req` rises, consecutive `step_req` rising edges are TICK_DIV+3 cycles apart.
- `resetn` low mid-sweep or mid-step: immediate abort, outputs to reset values; no resume.

## Test plan
- Power-up with `coordinatesready`=1, `reset`=1 static, release `resetn` → no `mem_we`, no `step_req` for 100 cycles.
- Toggle `coordinatesready` with x=12, y=7 → single write, `mem_addr`=572, `mem_wdata`=1, 2-cycle latency.
- x=80, y=0 toggle → no write; then x=79, y=47 → `mem_addr`=3839 written.
- Toggle `reset`, then toggle coordinates (x=1,y=1) at sweep cycle 100 → 3840 zero writes 0..3839 in order, then write to addr 81; `gen_count`=0.
- TICK_DIV=4, `start`=1, ack 1 cycle after req → `step_req` every 7 cycles, `gen_count` 1,2,3; drop `start` during STEP → that step completes, no further requests.
- Assert `resetn` low at sweep addr 2000 → `mem_we`=0 immediately; after release, ARM then IDLE, no sweep resumes.
